// File: rtl/mem_arbiter.sv
// Round-robin arbiter merging the instruction and data memory ports onto one
// shared memory port, with latched grants and a sticky hung-memory watchdog.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int INST_FIRST = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    inst_read,
    input  logic [ADDR_WIDTH-1:0]   inst_addr,
    output logic                    inst_resp,
    output logic [DATA_WIDTH-1:0]   inst_rdata,

    input  logic                    data_read,
    input  logic                    data_write,
    input  logic [DATA_WIDTH/8-1:0] data_mbe,
    input  logic [ADDR_WIDTH-1:0]   data_addr,
    input  logic [DATA_WIDTH-1:0]   data_wdata,
    output logic                    data_resp,
    output logic [DATA_WIDTH-1:0]   data_rdata,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [DATA_WIDTH/8-1:0] mem_mbe,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_resp,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    err_timeout
);

    localparam int MBE_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_I = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);
    localparam logic        PRIO_RESET  = (INST_FIRST != 0);

    logic [1:0]            state;
    logic                  prio;        // 1: inst wins the next contention
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic [MBE_WIDTH-1:0]  hold_mbe;
    logic                  hold_write;
    logic [15:0]           wd_count;
    logic [15:0]           wd_next;
    logic                  err_flag;

    logic inst_pend;
    logic data_pend;
    logic contended;
    logic pick_inst;
    logic busy;

    always_comb begin
        inst_pend = inst_read;
        data_pend = data_read | data_write;
        contended = inst_pend & data_pend;
        pick_inst = inst_pend & (~data_pend | prio);
        // Saturate so a very long hang cannot wrap back below TIMEOUT.
        wd_next   = (wd_count == '1) ? wd_count : wd_count + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prio       <= PRIO_RESET;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_mbe   <= '0;
            hold_write <= 1'b0;
            wd_count   <= '0;
            err_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wd_count <= '0;
                    if (pick_inst) begin
                        state      <= GNT_I;
                        hold_addr  <= inst_addr;
                        hold_wdata <= '0;
                        hold_mbe   <= '0;
                        hold_write <= 1'b0;
                    end else if (data_pend) begin
                        state      <= GNT_D;
                        hold_addr  <= data_addr;
                        hold_wdata <= data_wdata;
                        hold_mbe   <= data_mbe;
                        hold_write <= data_write;
                    end
                    if (contended) begin
                        prio <= ~pick_inst;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_resp) begin
                        state <= IDLE;
                    end else begin
                        wd_count <= wd_next;
                        if (wd_next == TIMEOUT_CNT) begin
                            err_flag <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy        = (state == GNT_I) || (state == GNT_D);
        mem_read    = busy & ~hold_write;
        mem_write   = busy & hold_write;
        mem_addr    = hold_addr;
        mem_wdata   = hold_wdata;
        mem_mbe     = hold_mbe;
        inst_resp   = (state == GNT_I) & mem_resp;
        data_resp   = (state == GNT_D) & mem_resp;
        inst_rdata  = inst_resp ? mem_rdata : '0;
        data_rdata  = data_resp ? mem_rdata : '0;
        err_timeout = err_flag;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port-to-one memory arbiter between the processor's instruction and data memory interfaces and a single shared memory (cache) port. Each upstream port uses the same read/write/resp handshake the core already drives. Contention is resolved round-robin, and the granted request is latched so the shared port sees stable signals until `mem_resp`. A per-transaction watchdog flags a hung memory.

## Interface
- `ADDR_WIDTH`, default 32: width of all address buses.
- `DATA_WIDTH`, default 32: width of all data buses. `mbe` width is DATA_WIDTH/8.
- `TIMEOUT`, default 255: maximum cycles in a grant state without `mem_resp` before `err_timeout` sets. Legal range is 1..65535.
- `INST_FIRST`, default 1: which port wins the first contention after reset. 1 selects inst; 0 selects data.

Ports:
- `clk` in 1: single clock, all state on its rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `inst_read` in 1: instruction fetch request. Held until `inst_resp`.
- `inst_addr` in ADDR_WIDTH: fetch address.
- `inst_resp` out 1: one-cycle completion pulse for the fetch.
- `inst_rdata` out DATA_WIDTH: fetch data, valid while `inst_resp`=1.
- `data_read` / `data_write` in 1 each: load or store request. Held until `data_resp`.
- `data_mbe` in DATA_WIDTH/8: store byte enables.
- `data_addr` in ADDR_WIDTH: load/store address.
- `data_wdata` in DATA_WIDTH: store data.
- `data_resp` out 1: one-cycle completion pulse for the load/store.
- `data_rdata` out DATA_WIDTH: load data, valid while `data_resp`=1.
- `mem_read` / `mem_write` out 1 each: shared-port request.
- `mem_mbe` out DATA_WIDTH/8: shared-port byte enables.
- `mem_addr` out ADDR_WIDTH: shared-port address.
- `mem_wdata` out DATA_WIDTH: shared-port write data.
- `mem_resp` in 1: shared-port completion pulse.
- `mem_rdata` in DATA_WIDTH: shared-port read data.
- `err_timeout` out 1: sticky watchdog flag. Cleared only by reset.

## Operation
- The FSM has three states: IDLE, GNT_I, GNT_D.
- In IDLE:
  - A pending request is `inst_read` for inst, or `data_read|data_write` for data.
  - If only one port is pending, that port wins.
  - If both are pending, the port named by the `prio` register wins.
  - The winner's addr, wdata, mbe and op are captured into hold registers. The state moves to GNT_I or GNT_D.
- `prio` flips to the loser on every contended grant. It is unchanged on uncontended grants. Its reset value is set by INST_FIRST.
- In GNT_x:
  - `mem_*` is driven from the hold registers only. Upstream changes during the grant are ignored.
  - `mem_read`/`mem_write` stay asserted every cycle until `mem_resp`.
- Response routing:
  - `mem_resp` in GNT_I drives `inst_resp`=1 combinationally in the same cycle, with `inst_rdata`=`mem_rdata`.
  - `mem_resp` in GNT_D does the same for `data_resp` and `data_rdata`.
  - The FSM returns to IDLE on the next edge.
- In IDLE, `mem_read`=`mem_write`=0, and `mem_addr`/`mem_wdata`/`mem_mbe` hold their last values.
- `data_read` and `data_write` both high is illegal. The arbiter treats it as a write (`mem_write`=1, `mem_read`=0).
- `mem_resp` in IDLE is ignored: no upstream resp is produced and no state change occurs.
- Watchdog:
  - A 16-bit counter clears on entry to GNT_x and increments each cycle in GNT_x without `mem_resp`.
  - When the count reaches TIMEOUT, `err_timeout` sets.
  - The grant is not aborted. The FSM keeps waiting for `mem_resp`.
- Reset mid-transaction: the FSM is forced to IDLE and all `mem_*` strobes drop immediately (asynchronous). The lost request is not replayed.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including `mem_addr`, `mem_wdata`, `mem_mbe`, `err_timeout`, and both resp outputs.
  - `prio`=INST_FIRST.
- Request-to-shared-port latency is 1 cycle. A request seen in IDLE at edge N drives `mem_*` from edge N onward.
- Response latency is 0 cycles: the upstream resp and rdata appear in the same cycle as `mem_resp`.
- Minimum transaction is 2 cycles (IDLE + GNT_x with immediate `mem_resp`). Back-to-back grants are separated by exactly one IDLE cycle.
- After its resp, a requester may keep its request high for a new access. The arbiter samples it again in the IDLE cycle.
- An upstream resp is never asserted for more than one cycle per transaction.

## Test plan
- Reset, then `inst_read`=1 with `inst_addr`=0x60 and `mem_resp` 3 cycles later, `mem_rdata`=0x00000013:
  - `mem_read`=1 with `mem_addr`=0x60 from cycle 1.
  - `inst_resp`=1 and `inst_rdata`=0x13 for exactly one cycle.
  - `data_resp` stays 0 throughout.
- Inst and data read both asserted continuously with INST_FIRST=1, memory responding in 1 cycle:
  - Grants go I, D, I, D.
  - Each grant is separated by one IDLE cycle with `mem_read`=0.
- Data store at 0x1000 with wdata 0xDEADBEEF and mbe 0b0011; upstream addr changed to 0x2000 mid-grant:
  - `mem_write`=1 holds `mem_addr`=0x1000, `mem_wdata`=0xDEADBEEF, `mem_mbe`=0b0011 until `mem_resp`.
  - `data_resp` pulses once.
- `data_read`=`data_write`=1 together: `mem_write`=1 and `mem_read`=0.
- TIMEOUT=4 with no `mem_resp`:
  - `err_timeout` rises after the 4th waiting cycle and `mem_read` is still held.
  - A later `mem_resp` completes the transaction normally, and `err_timeout` stays 1 until reset.
- Reset asserted (`rst`=0) during GNT_D:
  - `mem_write`, `mem_read` and `data_resp` go 0 immediately.
  - After release the FSM is in IDLE and `prio`=INST_FIRST.
